// File: rtl/ma_inverse.sv
// Inverse of the recursive moving-average filter: rebuilds x[n] from the filtered stream y[n]
// using x[n] = x[n-N] + ((y[n] - y[n-1]) >>> SHIFT), all modular, behind valid/ready.
module ma_inverse #(
  parameter int unsigned WINDOW_SIZE = 8,
  parameter int unsigned SHIFT       = 1,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SUM_W       = DATA_W + SHIFT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SUM_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              align_err,
  output logic [15:0]       sample_cnt
);

  logic [DATA_W-1:0] x_d_q [WINDOW_SIZE];
  logic [SUM_W-1:0]  y_prev_q;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic              align_err_q, align_err_d;
  logic [15:0]       sample_cnt_q;

  logic              accept;
  logic [SUM_W-1:0]  diff;
  logic [DATA_W-1:0] x_new;
  logic              misalign;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign diff     = in_data - y_prev_q;
  // Dropping the low SHIFT bits of the SUM_W-wide difference is the arithmetic shift,
  // already truncated to DATA_W bits.
  assign x_new    = diff[SUM_W-1:SHIFT] + x_d_q[WINDOW_SIZE-1];

  if (SHIFT > 0) begin : g_align
    assign misalign = |diff[SHIFT-1:0];
  end else begin : g_no_align
    assign misalign = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    align_err_d = align_err_q | (accept & misalign);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WINDOW_SIZE; i++) begin
        x_d_q[i] <= '0;
      end
      y_prev_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      align_err_q  <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      align_err_q <= align_err_d;
      if (accept) begin
        out_data_q <= x_new;
        y_prev_q   <= in_data;
        x_d_q[0]   <= x_new;
        for (int unsigned i = 1; i < WINDOW_SIZE; i++) begin
          x_d_q[i] <= x_d_q[i-1];
        end
        sample_cnt_q <= sample_cnt_q + 16'd1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign align_err  = align_err_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_ma_inverse.sv
// Bench for ma_inverse: a forward moving-average filter model generates y from random x,
// and the reconstructed stream must reproduce x exactly, in order, under random handshakes.
module tb_ma_inverse;

  localparam int unsigned N  = 8;
  localparam int unsigned SH = 1;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW + SH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, align_err;
  logic [SW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic [15:0]   sample_cnt;

  logic          in_valid8, in_ready8, out_valid8, out_ready8, align_err8;
  logic [8:0]    in_data8;
  logic [7:0]    out_data8;
  logic [15:0]   sample_cnt8;

  ma_inverse #(.WINDOW_SIZE(N), .SHIFT(SH), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .align_err(align_err), .sample_cnt(sample_cnt)
  );

  ma_inverse #(.WINDOW_SIZE(8), .SHIFT(1), .DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .align_err(align_err8), .sample_cnt(sample_cnt8)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Forward filter model: x history (index 0 newest), accumulator y, outstanding outputs.
  logic [DW-1:0] x_hist [N];
  logic [SW-1:0] y_acc;
  logic [DW-1:0] exp_q [$];
  int unsigned   acc_cnt;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) x_hist[i] = '0;
    y_acc = '0;
    exp_q.delete();
    acc_cnt = 0;
  endfunction

  function automatic logic [SW-1:0] fwd_y(input logic [DW-1:0] x);
    logic [SW-1:0] delta;
    delta = SW'(x) - SW'(x_hist[N-1]);
    return y_acc + (delta << SH);
  endfunction

  function automatic void fwd_commit(input logic [DW-1:0] x);
    y_acc = fwd_y(x);
    for (int i = N - 1; i > 0; i--) x_hist[i] = x_hist[i-1];
    x_hist[0] = x;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; in_data8 = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle against the forward model; handshake outcome predicted from the model.
  task automatic stream_cycle(input bit iv, input bit ordy, input string tag);
    logic [DW-1:0] x;
    logic [SW-1:0] y;
    bit exp_rdy, acc, drain;
    x = $urandom;
    y = fwd_y(x);
    in_valid = iv; out_ready = ordy;
    in_data = iv ? y : SW'($urandom);
    #1;
    exp_rdy = (exp_q.size() == 0) || ordy;
    n_cmp++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b want %b", tag, in_ready, exp_rdy);
    end
    drain = (exp_q.size() != 0) && ordy;
    acc = iv && exp_rdy;
    @(posedge clk); #1;
    if (drain) void'(exp_q.pop_front());
    if (acc) begin
      fwd_commit(x);
      exp_q.push_back(x);
      acc_cnt++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL %s out: got v=%b d=%0d want v=1 d=%0d", tag, out_valid, out_data, exp_q[0]);
      end
    end else if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s out_valid: got %b want 0", tag, out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || align_err !== 1'b0 || sample_cnt !== 16'd0
        || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%0d ae=%b cnt=%0d rdy=%b want 0 0 0 0 1",
               out_valid, out_data, align_err, sample_cnt, in_ready);
    end
  endtask

  task automatic test_impulse(input bit with_reset);
    logic [SW-1:0] ys [9];
    logic [DW-1:0] xs [9];
    if (with_reset) do_reset();
    for (int i = 0; i < 9; i++) begin
      ys[i] = (i < 8) ? SW'(10) : SW'(0);
      xs[i] = (i == 0) ? DW'(5) : DW'(0);
    end
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = ys[i];
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== xs[i]) begin
        n_fail++;
        $display("FAIL impulse[%0d]: got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, xs[i]);
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (align_err !== 1'b0 || sample_cnt !== 16'd9) begin
      n_fail++;
      $display("FAIL impulse_status: got ae=%b cnt=%0d want 0 9", align_err, sample_cnt);
    end
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_data = SW'(6 * ((i < 8) ? i + 1 : 8));
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== DW'(3)) begin
        n_fail++;
        $display("FAIL constant[%0d]: got v=%b d=%0d want v=1 d=3", i, out_valid, out_data);
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (sample_cnt !== 16'd11) begin
      n_fail++;
      $display("FAIL constant_cnt: got %0d want 11", sample_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] ys [2];
    logic [7:0] xs [2];
    ys[0] = 9'd400; ys[1] = 9'd88;
    xs[0] = 8'd200; xs[1] = 8'd100;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid8 = 1'b1; out_ready8 = 1'b1; in_data8 = ys[i];
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid8 !== 1'b1 || out_data8 !== xs[i]) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got v=%b d=%0d want v=1 d=%0d", i, out_valid8, out_data8, xs[i]);
      end
    end
    in_valid8 = 1'b0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    for (int i = 0; i < 3; i++) stream_cycle(1'b1, 1'b1, "bp_fill");
    for (int i = 0; i < 5; i++) stream_cycle(1'b1, 1'b0, "bp_hold");
    for (int i = 0; i < 10; i++) stream_cycle(1'b1, 1'b1, "bp_release");
    for (int i = 0; i < 2; i++) stream_cycle(1'b0, 1'b1, "bp_drain");
    n_cmp++;
    if (sample_cnt !== acc_cnt[15:0]) begin
      n_fail++;
      $display("FAIL bp_cnt: got %0d want %0d", sample_cnt, acc_cnt[15:0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stream_cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0), "random");
    end
    stream_cycle(1'b0, 1'b1, "random_drain");
    n_cmp++;
    if (sample_cnt !== acc_cnt[15:0] || align_err !== 1'b0) begin
      n_fail++;
      $display("FAIL random_status: got cnt=%0d ae=%b want cnt=%0d ae=0",
               sample_cnt, align_err, acc_cnt[15:0]);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_data = SW'(3);
    @(posedge clk); #1;
    n_cmp++;
    if (align_err !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_set: got %b want 1", align_err);
    end
    for (int i = 0; i < 20; i++) begin
      in_data = SW'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (align_err !== 1'b1) begin
        n_fail++;
        $display("FAIL misalign_sticky[%0d]: got %b want 1", i, align_err);
      end
    end
    do_reset();
    n_cmp++;
    if (align_err !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_clear: got %b want 0", align_err);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    stream_cycle(1'b1, 1'b0, "mid_fill");
    stream_cycle(1'b1, 1'b0, "mid_fill");
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = SW'($urandom);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    model_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || sample_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b cnt=%0d want 0 0", out_valid, sample_cnt);
    end
    test_impulse(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; in_data8 = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_impulse(1'b1);
    test_constant();
    test_wrap();
    test_back_pressure();
    test_random();
    test_misalign();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ma_inverse.md
Name: ma_inverse

Overview:
- Exact inverse of the team's recursive moving-average filter: takes the filter's output stream and reconstructs the original input samples.
- Forward filter relation: y[n] = y[n-1] + 2^SHIFT * (x[n] - x[n-WINDOW_SIZE]).
- This block computes x[n] = x[n-WINDOW_SIZE] + ((y[n] - y[n-1]) >> SHIFT).
- Sits on the receive side of a filtered data link (loopback checking, decimation pre-stage), behind a valid/ready stream.

Parameters:
- WINDOW_SIZE, 8, delay-line depth N; must equal the forward filter's window; >= 2.
- SHIFT, 1, log2 of the forward gain (gain 2 -> 1); 0..8.
- DATA_W, 32, width of reconstructed samples x.
- SUM_W, DATA_W+SHIFT, width of incoming filtered samples y (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  y sample present.
- in_ready  out  1  block accepts y this cycle.
- in_data  in  SUM_W  filtered sample y[n], two's complement, modular.
- out_valid  out  1  reconstructed sample present.
- out_ready  in  1  downstream accepts x.
- out_data  out  DATA_W  reconstructed sample x[n].
- align_err  out  1  sticky: a difference had nonzero low SHIFT bits.
- sample_cnt  out  16  number of samples accepted since reset, wraps at 2^16.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the following to 0: delay line x_d[0..N-1], y_prev, out_valid, out_data, align_err, sample_cnt.
  - in_ready is 1 in the cycle after reset.
  - This matches the forward filter's all-zero reset state, so both ends start aligned.
- Reset mid-stream: the in-flight output is discarded (out_valid=0) and all history is lost. Reset has priority over every other event in that cycle.
- Input handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, combinational; it must not depend on in_valid.
- Output handshake:
  - out_valid/out_data stay stable while out_valid && !out_ready.
  - The output register empties when out_ready=1 and no new accept occurs in that cycle.
- Accept in the same cycle as a downstream drain: allowed. The output register reloads, so throughput is 1 sample/clk.
- Latency: a y accepted at edge k gives out_valid=1 with x after edge k (1-cycle registered).
- Arithmetic, per accepted sample:
  - d = (in_data - y_prev) mod 2^SUM_W.
  - q = d[SUM_W-1:SHIFT], arithmetic shift; DATA_W bits.
  - x = (q + x_d[N-1]) mod 2^DATA_W.
  - All wrap-around is modular, with no saturation; this makes the inverse exact even when the forward accumulator wraps.
- State updates on accept:
  - y_prev <= in_data.
  - x_d[0] <= x; x_d[i] <= x_d[i-1] for i=1..N-1.
  - sample_cnt <= sample_cnt+1.
  - If d[SHIFT-1:0] != 0 (only when SHIFT>0), align_err <= 1. align_err clears only on reset.
- No accept means no state change: delay line, y_prev and counter hold.
- Back-pressure: if out_ready=0 and out_valid=1, in_ready=0 and in_data is ignored even if in_valid=1.
- SHIFT=0: d used directly and align_err is never set.

Test Plan:
- Impulse (N=8, SHIFT=1): reset, then feed y=10, 10, 10, 10, 10, 10, 10, 10, 0, with out_ready=1.
  - Required out_data: 5, 0, 0, 0, 0, 0, 0, 0, 0.
  - Each output appears 1 cycle after its accept; align_err=0.
- Constant input 3 (forward y = 6, 12, …, 48, 48, 48).
  - Required out_data: 3 for all 11 samples.
  - sample_cnt=11 at the end.
- Wrap-around (DATA_W=8, SUM_W=9): forward x = 200, 100 gives y = 400 mod 512 = 400, then 600 mod 512 = 88.
  - Required out_data: 200, 100.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - in_ready=0 and out_data holds its value for all 5 cycles.
  - On release, exactly one sample is drained per cycle, with none lost or duplicated.
- Misalignment: feed y=3 after reset (SHIFT=1).
  - align_err goes to 1 the cycle after accept and stays 1 through 20 further valid samples.
  - A later reset clears it.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0.
  - Next cycle: out_valid=0, sample_cnt=0.
  - Re-running the impulse test gives an identical result.
